// File: rtl/quantization_if.sv
// quantization_if: row-in / row-out handshake bundle for the JPEG forward quantizer.
interface quantization_if;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] data_in;
    logic [14:0] cnt_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic [2:0]  out_row;
    logic        out_last;
    logic        sat_flag;
    modport master (output in_valid, data_in, cnt_in, out_ready,
                    input  in_ready, out_valid, data_out, out_row, out_last, sat_flag);
    modport slave  (input  in_valid, data_in, cnt_in, out_ready,
                    output in_ready, out_valid, data_out, out_row, out_last, sat_flag);
endinterface

// File: rtl/quantization.sv
// quantization: divides a row of eight signed 12-bit DCT coefficients by the row's table entries
// via reciprocal multiply, 2-stage pipeline, saturating to signed 8-bit.
module quantization (
    input logic          clk,
    input logic          rst,
    quantization_if.slave bus
);
    // round(65536/Q) per [row][coeff]; Q=0 entries map to 0 so they always quantize to 0
    localparam logic [12:0] recip_rom [8][8] = '{
        '{8{13'd0}},
        '{8{13'd0}},
        '{13'd4096, 13'd5958, 13'd6554, 13'd4096, 13'd2731, 13'd1638, 13'd0, 13'd0},
        '{13'd5461, 13'd5461, 13'd4681, 13'd3449, 13'd2521, 13'd1130, 13'd0, 13'd0},
        '{13'd4681, 13'd5041, 13'd4096, 13'd2731, 13'd1638, 13'd1150, 13'd0, 13'd0},
        '{13'd4681, 13'd3855, 13'd2979, 13'd2260, 13'd1285, 13'd753,  13'd0, 13'd0},
        '{13'd3641, 13'd2979, 13'd1771, 13'd1170, 13'd964,  13'd0,    13'd0, 13'd0},
        '{13'd2731, 13'd1872, 13'd1192, 13'd1024, 13'd0,    13'd0,    13'd0, 13'd0}
    };

    logic        en;
    logic        v1_q, v1_d, v2_q, v2_d;
    logic [2:0]  r1_q, r1_d, row_q, row_d;
    logic [11:0] m_q [8], m_d [8];
    logic [12:0] rc_q [8], rc_d [8];
    logic [7:0]  s_q, s_d;
    logic [63:0] dout_q, dout_d;
    logic        last_q, last_d, sat_q, sat_d;
    logic [7:0]  sat;
    logic [7:0]  res [8];
    logic        unused_cnt;

    assign unused_cnt = ^bus.cnt_in[14:3];
    assign en = !v2_q | bus.out_ready;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [23:0] p;
        logic [8:0]  q;
        assign p = 24'(m_q[i]) * 24'(rc_q[i]);
        assign q = 9'((25'(p) + 25'd32768) >> 16);
        // magnitude 128 is representable only on the negative side
        assign sat[i] = s_q[i] ? (q > 9'd128) : (q > 9'd127);
        assign res[i] = s_q[i] ? (sat[i] ? 8'h80 : 8'(-q)) : (sat[i] ? 8'h7f : q[7:0]);
    end

    always_comb begin
        v1_d = en ? bus.in_valid : v1_q;
        r1_d = r1_q;
        m_d  = m_q;
        rc_d = rc_q;
        s_d  = s_q;
        if (en && bus.in_valid) begin
            r1_d = bus.cnt_in[2:0];
            for (int k = 0; k < 8; k++) begin
                s_d[k]  = bus.data_in[95-12*k];
                m_d[k]  = bus.data_in[95-12*k] ? 12'(-bus.data_in[95-12*k -: 12]) : bus.data_in[95-12*k -: 12];
                rc_d[k] = recip_rom[bus.cnt_in[2:0]][k];
            end
        end
    end

    always_comb begin
        v2_d   = en ? v1_q : v2_q;
        last_d = en ? (v1_q && r1_q == 3'd7) : last_q;
        sat_d  = sat_q | (en & v1_q & (|sat));
        dout_d = dout_q;
        row_d  = row_q;
        if (en && v1_q) begin
            row_d = r1_q;
            for (int k = 0; k < 8; k++) dout_d[63-8*k -: 8] = res[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            r1_q   <= '0;
            row_q  <= '0;
            m_q    <= '{default: '0};
            rc_q   <= '{default: '0};
            s_q    <= '0;
            dout_q <= '0;
            last_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            r1_q   <= r1_d;
            row_q  <= row_d;
            m_q    <= m_d;
            rc_q   <= rc_d;
            s_q    <= s_d;
            dout_q <= dout_d;
            last_q <= last_d;
            sat_q  <= sat_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = v2_q;
    assign bus.data_out  = dout_q;
    assign bus.out_row   = row_q;
    assign bus.out_last  = last_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_quantization.sv
// tb_quantization: directed checks of the forward quantizer against hand-computed rows.
module tb_quantization;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    quantization_if bus ();
    quantization dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input int c0, c1, c2, c3, c4, c5, c6, c7);
        return {12'(c0), 12'(c1), 12'(c2), 12'(c3), 12'(c4), 12'(c5), 12'(c6), 12'(c7)};
    endfunction

    task automatic do_rst();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // called at a negedge with out_ready=1: checks latency then the produced row
    task automatic one(input string tag, input logic [14:0] cnt, input logic [95:0] din,
                       input logic [63:0] exp, input logic [2:0] row, input logic last);
        bus.in_valid = 1'b1;
        bus.cnt_in   = cnt;
        bus.data_in  = din;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = '1;
        chk({tag, "_lat"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, bus.data_out, exp);
        chk({tag, "_row"}, 64'(bus.out_row), 64'(row));
        chk({tag, "_last"}, 64'(bus.out_last), 64'(last));
    endtask

    logic [63:0] exp_bp [8];
    logic [63:0] held;
    logic        stalled;
    int          idx_in, idx_out, cyc;
    logic        fire_in, fire_out;

    initial begin
        exp_bp = '{64'h0, 64'h0, 64'h06F7_0000_0000_0000, 64'h08F8_0000_0000_0000,
                   64'h07F8_0000_0000_0000, 64'h07FA_0000_0000_0000,
                   64'h06FB_0000_0000_0000, 64'h04FD_0000_0000_0000};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        bus.cnt_in    = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", bus.data_out, 64'd0);
        chk("rst_row", 64'(bus.out_row), 64'd0);
        chk("rst_last", 64'(bus.out_last), 64'd0);
        chk("rst_sat", 64'(bus.sat_flag), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        one("basic", 15'h7FF2, mk(100, -50, 0, 0, 0, 0, 0, 0), 64'h06FB_0000_0000_0000, 3'd2, 1'b0);
        one("rnd_p8", 15'd2, mk(8, 0, 0, 0, 0, 0, 0, 0), 64'h0100_0000_0000_0000, 3'd2, 1'b0);
        one("rnd_m8", 15'd2, mk(-8, 0, 0, 0, 0, 0, 0, 0), 64'hFF00_0000_0000_0000, 3'd2, 1'b0);
        one("rnd_p7", 15'd2, mk(7, 0, 0, 0, 0, 0, 0, 0), 64'h0, 3'd2, 1'b0);
        one("zero_r0", 15'd0, mk(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047), 64'h0, 3'd0, 1'b0);
        one("zero_r7", 15'd7, mk(100, 0, 0, -96, -2048, -2048, -2048, -2048),
            64'h0400_00FE_0000_0000, 3'd7, 1'b1);
        chk("sat_clean", 64'(bus.sat_flag), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("valid_falls", 64'(bus.out_valid), 64'd0);

        one("sat_pos", 15'd2, mk(0, 0, 2047, 0, 0, 0, 0, 0), 64'h0000_7F00_0000_0000, 3'd2, 1'b0);
        chk("sat_set", 64'(bus.sat_flag), 64'd1);
        one("sat_neg", 15'd2, mk(0, 0, -2048, 0, 0, 0, 0, 0), 64'h0000_8000_0000_0000, 3'd2, 1'b0);
        one("after_sat", 15'd2, mk(8, 0, 0, 0, 0, 0, 0, 0), 64'h0100_0000_0000_0000, 3'd2, 1'b0);
        chk("sat_sticky", 64'(bus.sat_flag), 64'd1);
        do_rst();
        chk("sat_cleared", 64'(bus.sat_flag), 64'd0);

        idx_in = 0;
        idx_out = 0;
        stalled = 1'b0;
        held = '0;
        for (cyc = 0; cyc < 300 && idx_out < 8; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                chk("bp_hold_data", bus.data_out, held);
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (idx_in < 8);
            bus.cnt_in    = 15'(idx_in);
            bus.data_in   = mk(100, -100, 0, 0, 0, 0, 0, 0);
            #1;
            fire_in  = bus.in_valid & bus.in_ready;
            fire_out = bus.out_valid & bus.out_ready;
            if (fire_out) begin
                chk("bp_data", bus.data_out, exp_bp[idx_out]);
                chk("bp_row", 64'(bus.out_row), 64'(idx_out));
                chk("bp_last", 64'(bus.out_last), 64'(idx_out == 7));
            end
            stalled = bus.out_valid & !bus.out_ready;
            held = bus.data_out;
            @(posedge clk);
            idx_in  += int'(fire_in);
            idx_out += int'(fire_out);
        end
        chk("bp_all_rows", 64'(idx_out), 64'd8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.cnt_in    = 15'd2;
        bus.data_in   = mk(100, -50, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        bus.cnt_in    = 15'd7;
        bus.data_in   = mk(0, 0, 2047, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("flight_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_data", bus.data_out, 64'd0);
        chk("mrst_row", 64'(bus.out_row), 64'd0);
        chk("mrst_last", 64'(bus.out_last), 64'd0);
        chk("mrst_sat", 64'(bus.sat_flag), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("mrst_no_output", 64'(bus.out_valid), 64'd0);
        end
        chk("mrst_sat_final", 64'(bus.sat_flag), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
